// File: rtl/shift_tx_if.sv
// Parallel-word handshake into the serial transmitter.
// The producer drives valid/data and the transmitter returns ready.
interface shift_tx_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/shift_tx.sv
// Parallel-to-serial transmitter feeding a shift-register chain, MSB first.
// A one-word pending buffer allows back-to-back words with no bubble.
module shift_tx #(
  parameter int WIDTH = 16,
  parameter int GAP   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  shift_tx_if.slave        s_in,
  output logic             ser_data,
  output logic             shift_en,
  output logic             busy,
  output logic             word_done,
  output logic [CNT_W-1:0] word_count
);

  localparam int BCW    = $clog2(WIDTH);
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam bit NO_GAP = (GAP == 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_pend;
  logic               r_pend_full;
  logic [WIDTH-1:0]   r_shift;
  logic [BCW-1:0]     r_bit_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_ser;
  logic               r_en;
  logic               r_done;
  logic               r_busy;
  logic [CNT_W-1:0]   r_count;

  logic w_ready;
  logic w_accept;
  logic w_last_bit;
  logic w_gap_end;
  logic w_free;
  logic w_load;
  logic w_to_idle;
  logic w_pend_full_nxt;
  logic w_busy_nxt;

  // Ready depends only on reset and buffer state, never on in_valid.
  assign w_ready    = !rst && !r_pend_full;
  assign w_accept   = s_in.in_valid && w_ready;
  assign w_last_bit = (r_state == ST_SHIFT) && (r_bit_cnt == BCW'(WIDTH - 1));
  assign w_gap_end  = (r_state == ST_GAP) && (r_gap_cnt == GAP_W'(GAP - 1));

  // The shifter can take a new word at this edge (idle, final bit without gap, or gap over).
  assign w_free          = (r_state == ST_IDLE) || (w_last_bit && NO_GAP) || w_gap_end;
  assign w_load          = w_free && r_pend_full;
  assign w_to_idle       = w_free && !r_pend_full;
  assign w_pend_full_nxt = w_accept || (r_pend_full && !w_load);
  assign w_busy_nxt      = !w_to_idle || w_pend_full_nxt;

  assign s_in.in_ready = w_ready;
  assign ser_data      = r_ser;
  assign shift_en      = r_en;
  assign busy          = r_busy;
  assign word_done     = r_done;
  assign word_count    = r_count;

  // Transmitter state machine, pending buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pend      <= '0;
      r_pend_full <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_ser       <= 1'b0;
      r_en        <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_count     <= '0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_pend_full <= w_pend_full_nxt;
      if (w_accept) begin
        r_pend <= s_in.in_data;
      end
      if (w_last_bit) begin
        r_count <= r_count + CNT_W'(1);
      end
      if (w_load) begin
        // MSB goes out next cycle; the shifter keeps only the bits still to send.
        r_state   <= ST_SHIFT;
        r_ser     <= r_pend[WIDTH-1];
        r_shift   <= {r_pend[WIDTH-2:0], 1'b0};
        r_en      <= 1'b1;
        r_done    <= 1'b0;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_ser  <= 1'b0;
            r_en   <= 1'b0;
            r_done <= 1'b0;
          end
          ST_SHIFT: begin
            if (w_last_bit) begin
              r_ser  <= 1'b0;
              r_en   <= 1'b0;
              r_done <= 1'b0;
              if (NO_GAP) begin
                r_state <= ST_IDLE;
              end else begin
                r_state   <= ST_GAP;
                r_gap_cnt <= '0;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + BCW'(1);
              r_ser     <= r_shift[WIDTH-1];
              r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
              r_done    <= (r_bit_cnt == BCW'(WIDTH - 2));
            end
          end
          ST_GAP: begin
            r_ser  <= 1'b0;
            r_en   <= 1'b0;
            r_done <= 1'b0;
            if (w_gap_end) begin
              r_state <= ST_IDLE;
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_ser   <= 1'b0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shift_tx.sv
// Bench for shift_tx: two instances (GAP=0 and GAP=2 with a 3-bit counter) share one
// stimulus; a timeline model schedules each accepted word and predicts every output.
module tb_shift_tx;
  localparam int W    = 16;
  localparam int GAP1 = 2;
  localparam int CW1  = 3;
  localparam int MAXE = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [W-1:0] in_data = '0;

  logic ser0, en0, busy0, done0;
  logic [15:0] cnt0;
  logic ser1, en1, busy1, done1;
  logic [CW1-1:0] cnt1;
  logic [W-1:0] chain0 = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp0 = 0;

  int m_n [2];
  int m_last [2];
  int m_acc [2][MAXE];
  int m_start [2][MAXE];
  logic [W-1:0] m_word [2][MAXE];
  bit acc_flag [2];
  int gapv [2];
  int maskv [2];

  always #5 clk = ~clk;

  shift_tx_if #(.WIDTH(W)) bus0 ();
  shift_tx_if #(.WIDTH(W)) bus1 ();
  assign bus0.in_valid = in_valid;
  assign bus0.in_data  = in_data;
  assign bus1.in_valid = in_valid;
  assign bus1.in_data  = in_data;

  shift_tx #(.WIDTH(W), .GAP(0), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .s_in(bus0), .ser_data(ser0), .shift_en(en0),
    .busy(busy0), .word_done(done0), .word_count(cnt0)
  );

  shift_tx #(.WIDTH(W), .GAP(GAP1), .CNT_W(CW1)) u_dut1 (
    .clk(clk), .rst(rst), .s_in(bus1), .ser_data(ser1), .shift_en(en1),
    .busy(busy1), .word_done(done1), .word_count(cnt1)
  );

  // Downstream 16-bit chain fed by instance 0.
  always @(posedge clk) begin
    if (en0) chain0 <= {chain0[W-2:0], ser0};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected outputs in cycle c, from the schedule of accepted words.
  function automatic void model_out(input int u, input int c, output logic en, output logic sd,
                                    output logic dn, output logic bz, output logic rd,
                                    output logic [31:0] cnt);
    int s, e;
    en = 1'b0; sd = 1'b0; dn = 1'b0; bz = 1'b0; rd = !rst; cnt = 32'd0;
    for (int i = 0; i < m_n[u]; i++) begin
      s = m_start[u][i];
      e = s + W - 1;
      if (c >= s && c <= e) begin
        en = 1'b1;
        sd = m_word[u][i][e - c];
        dn = (c == e);
      end
      if (e < c) cnt = cnt + 32'd1;
      if (c >= s && c <= e + gapv[u]) bz = 1'b1;
      if (c >= m_acc[u][i] && c < s) begin
        bz = 1'b1;
        rd = 1'b0;
      end
    end
    cnt = cnt & maskv[u];
  endfunction

  task automatic check_cycle();
    logic en, sd, dn, bz, rd;
    logic [31:0] cnt;
    for (int u = 0; u < 2; u++) begin
      model_out(u, cyc, en, sd, dn, bz, rd, cnt);
      check_eq($sformatf("u%0d.shift_en", u), 32'(u == 0 ? en0 : en1), 32'(en));
      check_eq($sformatf("u%0d.ser_data", u), 32'(u == 0 ? ser0 : ser1), 32'(sd));
      check_eq($sformatf("u%0d.word_done", u), 32'(u == 0 ? done0 : done1), 32'(dn));
      check_eq($sformatf("u%0d.busy", u), 32'(u == 0 ? busy0 : busy1), 32'(bz));
      check_eq($sformatf("u%0d.in_ready", u), 32'(u == 0 ? bus0.in_ready : bus1.in_ready), 32'(rd));
      check_eq($sformatf("u%0d.word_count", u), (u == 0) ? 32'(cnt0) : 32'(cnt1), cnt);
    end
  endtask

  // One clock: update the model at the edge, then check outputs mid-cycle.
  task automatic step();
    logic en, sd, dn, bz;
    logic [31:0] cnt;
    logic rdy [2];
    int s;
    for (int u = 0; u < 2; u++) model_out(u, cyc, en, sd, dn, bz, rdy[u], cnt);
    @(posedge clk);
    cyc++;
    for (int u = 0; u < 2; u++) begin
      acc_flag[u] = 1'b0;
      if (rst) begin
        m_n[u] = 0;
        m_last[u] = -1000;
      end else if (in_valid && rdy[u] && m_n[u] < MAXE) begin
        s = (cyc + 1 > m_last[u] + gapv[u] + 1) ? cyc + 1 : m_last[u] + gapv[u] + 1;
        m_acc[u][m_n[u]] = cyc;
        m_start[u][m_n[u]] = s;
        m_word[u][m_n[u]] = in_data;
        m_n[u]++;
        m_last[u] = s + W - 1;
        acc_flag[u] = 1'b1;
      end
    end
    @(negedge clk);
    check_cycle();
  endtask

  task automatic send_word(input logic [W-1:0] w);
    bit got;
    in_valid = 1'b1;
    in_data = w;
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      step();
      got = acc_flag[0];
    end
    check_eq("send_accept", 32'(got), 32'd1);
    if (got) exp0++;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    int st, en_seen;
    gapv[0] = 0;  gapv[1] = GAP1;
    maskv[0] = 32'hFFFF; maskv[1] = (1 << CW1) - 1;
    for (int u = 0; u < 2; u++) begin
      m_n[u] = 0;
      m_last[u] = -1000;
      acc_flag[u] = 1'b0;
    end

    // Reset held 3 cycles while a word is offered.
    rst = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF;
    repeat (3) step();
    check_eq("reset_ready", 32'(bus0.in_ready), 32'd0);
    rst = 1'b0;
    idle(6);
    check_eq("reset_count", 32'(cnt0), 32'd0);

    // Single word through the chain.
    send_word(16'hA5C3);
    idle(24);
    check_eq("chain_a5c3", 32'(chain0), 32'h0000A5C3);
    check_eq("count_single", 32'(cnt0), 32'd1);
    check_eq("busy_after", 32'(busy0), 32'd0);

    // Back-to-back pair, then a pair that exercises the gap instance.
    send_word(16'h1234);
    send_word(16'hFFFF);
    idle(40);
    check_eq("chain_ffff", 32'(chain0), 32'h0000FFFF);
    check_eq("count_b2b", 32'(cnt0), 32'd3);
    send_word(16'h8001);
    send_word(16'h0001);
    idle(40);

    // Backpressure: valid held across three words.
    send_word(16'h3C5A);
    send_word(16'h9669);
    send_word(16'hC3A5);
    idle(60);
    check_eq("chain_c3a5", 32'(chain0), 32'h0000C3A5);
    check_eq("count_bp", 32'(cnt0), 32'(exp0));

    // Random traffic.
    for (int i = 0; i < 700; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = W'($urandom);
      step();
      if (acc_flag[0]) exp0++;
    end
    idle(60);
    check_eq("count_random", 32'(cnt0), 32'(exp0 & 32'hFFFF));

    // Reset after 5 bits of a word, with a second word pending.
    send_word(16'hF0F0);
    st = m_start[0][m_n[0] - 1];
    send_word(16'h0F0F);
    in_valid = 1'b0;
    for (int t = 0; t < 40 && cyc < st + 4; t++) step();
    rst = 1'b1;
    step();
    check_eq("midrst_en", 32'(en0), 32'd0);
    check_eq("midrst_count", 32'(cnt0), 32'd0);
    rst = 1'b0;
    en_seen = 0;
    for (int t = 0; t < 40; t++) begin
      step();
      if (en0 || done0) en_seen++;
    end
    check_eq("midrst_silent", 32'(en_seen), 32'd0);
    check_eq("midrst_count2", 32'(cnt0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_tx.md
Name: shift_tx

Overview:
Parallel-to-serial transmitter that feeds the 16-bit serial shift-register chain. It accepts parallel words over a valid/ready handshake and drives one serial bit plus a shift-enable strobe per cycle, MSB first. After WIDTH strobes, the downstream register holds the word with bit i in stage i. A one-entry pending buffer lets the next word be accepted while the current word shifts, giving gap-free back-to-back streaming.

Parameters:
WIDTH, 16, bits per word (>= 2)
GAP, 0, forced idle cycles (shift_en=0) between consecutive words (>= 0)
CNT_W, 16, width of the transmitted-word counter (wraps)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  in_data valid
in_ready  output  1  pending buffer empty; word accepted when in_valid & in_ready at an edge
in_data  input  WIDTH  parallel word to transmit
ser_data  output  1  serial bit to the downstream data_in
shift_en  output  1  strobe to the downstream shift_en; ser_data meaningful only when 1
busy  output  1  shifter not in IDLE, or pending buffer full
word_done  output  1  one-cycle pulse coincident with the last bit (LSB) of each word
word_count  output  CNT_W  count of completed words, wraps modulo 2^CNT_W

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, pending buffer empty, shifter cleared, bit counter=0, gap counter=0. Outputs after that edge: ser_data=0, shift_en=0, busy=0, word_done=0, word_count=0. in_ready=0 while rst=1 and 1 after it. A word presented during reset is not accepted.
- All outputs except in_ready are registered. in_ready = !pend_full, with no combinational path from in_valid.
- Accept: at an edge with in_valid & in_ready, in_data is stored in pend and pend_full is set. pend cannot be refilled on the same edge it drains.
- States:
  - IDLE: if pend_full, then at the edge load shifter<=pend, clear pend_full, bit counter<=0, go to SHIFT. Otherwise stay.
  - SHIFT: per cycle, shift_en=1 and ser_data=shifter[WIDTH-1], and the shifter shifts left at each edge.
    - In the cycle with bit counter==WIDTH-1, word_done=1, and word_count increments at the end of that cycle.
    - Then: if GAP>0, go to GAP with gap counter<=0.
    - Else if pend_full, load pend in place (the next MSB appears the following cycle with no bubble) and stay in SHIFT.
    - Else go to IDLE.
  - GAP: shift_en=0, ser_data=0 for exactly GAP cycles. Then, if pend_full, load and go to SHIFT; else go to IDLE.
- Latency: accept at edge k puts pend_full after k. From IDLE, the load happens at edge k+1, so the MSB is on ser_data in cycle k+1..k+2, i.e. 2 cycles after acceptance.
- Throughput with GAP=0: one bit per cycle sustained, provided each next word is accepted at least 1 cycle before the current LSB.
- ser_data=0 whenever shift_en=0.
- Backpressure: while pend_full, in_ready=0 and in_data is ignored. The held word is never overwritten or dropped.
- Reset mid-word: the partial word is abandoned, pend is discarded, word_done does not fire, and all outputs return to reset values after the reset edge.
- word_count wraps from 2^CNT_W-1 to 0 silently.
- busy=1 from the edge that sets pend_full until the edge that returns to IDLE with pend empty.

Test Plan:
1. Reset: assert rst 3 cycles with in_valid=1, in_data=0xFFFF. Required: ser_data=0, shift_en=0, busy=0, word_count=0, in_ready=0 during reset; no transmission after reset unless in_valid is re-presented.
2. Single word 0xA5C3, GAP=0, output chained to the 16-bit shift register. Required: MSB 2 cycles after accept; ser_data sequence 1010010111000011 over 16 consecutive shift_en cycles; word_done only on the 16th; register q=0xA5C3; word_count=1; busy=0 afterwards.
3. Back-to-back 0x1234 then 0xFFFF, second offered as soon as in_ready rises, GAP=0. Required: 32 contiguous shift_en cycles, word_done at bits 16 and 32, word_count=2.
4. GAP=2 with two words 0x8001, 0x0001. Required: exactly 2 cycles with shift_en=0 and ser_data=0 between the LSB of word 1 and the MSB of word 2.
5. Backpressure: hold in_valid=1 with 3 distinct words during streaming. Required: in_ready=0 whenever pend is full; all 3 words emitted in order, intact; word_count=3.
6. Reset after 5 bits of 0xF0F0 with pend holding 0x0F0F. Required: the cycle after the reset edge has shift_en=0, word_done never pulses, word_count=0, and 0x0F0F is never transmitted.
